// File: rtl/sa_div_pkg.sv
// sa_div_pkg: shared FSM state encoding and default operand width for the divider scheduler
package sa_div_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sa_div_scheduler_if.sv
// sa_div_scheduler_if: two-requester divide request bus plus single result channel
//   req_valid/req_ready : per-requester handshake, bit i = requester i
//   req_dividend/divisor: signed operands, requester i in [i*WIDTH +: WIDTH]
//   res_*               : result channel, valid/ready handshake
interface sa_div_scheduler_if import sa_div_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_dividend;
    logic [2*WIDTH-1:0] req_divisor;
    logic               res_valid;
    logic               res_ready;
    logic               res_id;
    logic [WIDTH-1:0]   res_quotient;
    logic [WIDTH-1:0]   res_remainder;
    logic               res_dbz;
    logic               res_ovf;
    modport master (
        output req_valid, req_dividend, req_divisor, res_ready,
        input  req_ready, res_valid, res_id, res_quotient, res_remainder, res_dbz, res_ovf
    );
    modport slave (
        input  req_valid, req_dividend, req_divisor, res_ready,
        output req_ready, res_valid, res_id, res_quotient, res_remainder, res_dbz, res_ovf
    );
endinterface

// File: rtl/sa_div_core.sv
// sa_div_core: iterative unsigned restoring divider, one quotient bit per cycle
//   clk, rst           : clock, asynchronous active-high reset
//   i_load             : latch operands and perform the first step
//   i_start            : keep stepping until o_done
//   i_dividend/divisor : unsigned magnitudes
//   o_done             : all WIDTH steps complete, outputs valid
//   o_quotient/remainder: unsigned results
module sa_div_core import sa_div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    logic [WIDTH-1:0] r_rem, r_quo, r_div;
    logic [CNT_W-1:0] r_cnt;
    // One restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] rem, input logic [WIDTH-1:0] quo, input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {rem, quo[WIDTH-1]};
        diff = sh - {1'b0, d};
        return diff[WIDTH] ? {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    endfunction
    // The load cycle already performs step 1, so WIDTH steps finish WIDTH-1 cycles after load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            {r_rem, r_quo} <= step('0, i_dividend, i_divisor);
            r_div          <= i_divisor;
            r_cnt          <= CNT_W'(1);
        end else if (i_start && !o_done) begin
            {r_rem, r_quo} <= step(r_rem, r_quo, r_div);
            r_cnt          <= r_cnt + CNT_W'(1);
        end
    end
    assign o_done      = r_cnt == CNT_W'(WIDTH);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
endmodule

// File: rtl/sa_div_scheduler.sv
// sa_div_scheduler: round-robin arbiter for two requesters sharing one signed iterative divider
//   clk, rst : clock, asynchronous active-high reset
//   io_bus   : slave side of sa_div_scheduler_if (request handshake, operands, result channel)
module sa_div_scheduler import sa_div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_div_scheduler_if.slave    io_bus
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    state_t           r_state;
    logic             r_rr, r_neg_q, r_neg_r, r_ovf_pend;
    logic             r_res_valid, r_res_id, r_res_dbz, r_res_ovf;
    logic [WIDTH-1:0] r_res_q, r_res_r;
    logic             w_gnt, w_xfer, w_load, w_core_done;
    logic [WIDTH-1:0] w_a, w_b, w_a_mag, w_b_mag, w_cq, w_cr;
    assign w_gnt   = &io_bus.req_valid ? r_rr : io_bus.req_valid[1];
    // Gated with rst so nothing is offered while reset is held.
    assign io_bus.req_ready = (r_state == IDLE && !rst) ? (io_bus.req_valid & (w_gnt ? 2'b10 : 2'b01)) : 2'b00;
    assign w_xfer  = |(io_bus.req_valid & io_bus.req_ready);
    assign w_a     = w_gnt ? io_bus.req_dividend[WIDTH +: WIDTH] : io_bus.req_dividend[0 +: WIDTH];
    assign w_b     = w_gnt ? io_bus.req_divisor[WIDTH +: WIDTH] : io_bus.req_divisor[0 +: WIDTH];
    // Magnitude of the most-negative value wraps to itself, which is its correct unsigned magnitude.
    assign w_a_mag = w_a[WIDTH-1] ? -w_a : w_a;
    assign w_b_mag = w_b[WIDTH-1] ? -w_b : w_b;
    assign w_load  = w_xfer && w_b != '0;
    sa_div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_start     (r_state == RUN),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_done      (w_core_done),
        .o_quotient  (w_cq),
        .o_remainder (w_cr)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_q     <= '0;
            r_res_r     <= '0;
            r_res_dbz   <= 1'b0;
            r_res_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_rr       <= ~w_gnt;
                    r_res_id   <= w_gnt;
                    r_neg_q    <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
                    r_neg_r    <= w_a[WIDTH-1];
                    r_ovf_pend <= w_a == MIN_NEG && w_b == '1;
                    if (w_b == '0) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                        r_res_q     <= '1;
                        r_res_r     <= w_a;
                        r_res_dbz   <= 1'b1;
                        r_res_ovf   <= 1'b0;
                    end else begin
                        r_state <= RUN;
                    end
                end
                // MIN/-1 yields unsigned 2^(WIDTH-1) with equal signs, i.e. the wrapped most-negative value.
                RUN: if (w_core_done) begin
                    r_state     <= DONE;
                    r_res_valid <= 1'b1;
                    r_res_q     <= r_neg_q ? -w_cq : w_cq;
                    r_res_r     <= r_neg_r ? -w_cr : w_cr;
                    r_res_dbz   <= 1'b0;
                    r_res_ovf   <= r_ovf_pend;
                end
                DONE: if (io_bus.res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign io_bus.res_valid     = r_res_valid;
    assign io_bus.res_id        = r_res_id;
    assign io_bus.res_quotient  = r_res_q;
    assign io_bus.res_remainder = r_res_r;
    assign io_bus.res_dbz       = r_res_dbz;
    assign io_bus.res_ovf       = r_res_ovf;
endmodule

// File: tb/tb_sa_div_scheduler.sv
// tb_sa_div_scheduler: directed stimulus with a transaction-level signed-division model and per-cycle compare
module tb_sa_div_scheduler;
    localparam int W    = 8;
    localparam int MINV = -(1 << (W - 1));
    typedef struct {
        int id;
        int q;
        int r;
        int dbz;
        int ovf;
        int lat;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    sa_div_scheduler_if #(.WIDTH(W)) bus();
    sa_div_scheduler #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io_bus(bus.slave));
    always #5 clk = ~clk;
    int   n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0, n_res = 0, obs_lat = 0;
    bit   busy = 0, rr = 0, seen = 0, prev_hold = 0;
    logic [18:0] prev_out;
    res_t eq[$];
    res_t lg[$];
    always @(posedge clk) cyc++;
    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired without the required event (cycle %0d)", nm, cyc);
    endtask
    // Division semantics straight from the rules: SV int / and % truncate toward zero.
    function automatic res_t model(input int id, input int a, input int b);
        res_t e;
        e.id  = id;
        e.dbz = (b == 0) ? 1 : 0;
        e.ovf = (a == MINV && b == -1) ? 1 : 0;
        e.q   = e.dbz ? -1 : e.ovf ? MINV : a / b;
        e.r   = e.dbz ? a : e.ovf ? 0 : a % b;
        e.lat = e.dbz ? 1 : W + 1;
        return e;
    endfunction
    // Inputs change only at posedge+1, so a negedge sample sees exactly what the next edge will act on.
    always @(negedge clk) begin
        logic [18:0] cur;
        int   exp_rdy;
        res_t e, o;
        cur = {bus.res_id, bus.res_quotient, bus.res_remainder, bus.res_dbz, bus.res_ovf};
        if (rst) begin
            chk("reset_outputs", int'({bus.res_valid, cur, bus.req_ready}), 0);
            eq.delete();
            busy = 0; rr = 0; seen = 0; prev_hold = 0;
        end else begin
            exp_rdy = busy ? 0 : (&bus.req_valid) ? (rr ? 2 : 1) : int'(bus.req_valid);
            chk("req_ready", int'(bus.req_ready), exp_rdy);
            if (bus.res_valid) begin
                if (prev_hold) chk("res_hold", int'(cur), int'(prev_out));
                if (eq.size() == 0) begin
                    fail("unexpected_res_valid");
                end else begin
                    e = eq[0];
                    if (!seen) begin
                        obs_lat = cyc - acc_cyc + 1;
                        chk("latency", obs_lat, e.lat);
                        seen = 1;
                    end
                    chk("res_id", int'(bus.res_id), e.id);
                    chk("res_quotient", int'($signed(bus.res_quotient)), e.q);
                    chk("res_remainder", int'($signed(bus.res_remainder)), e.r);
                    chk("res_dbz", int'(bus.res_dbz), e.dbz);
                    chk("res_ovf", int'(bus.res_ovf), e.ovf);
                    if (bus.res_ready) begin
                        o.id  = int'(bus.res_id);
                        o.q   = int'($signed(bus.res_quotient));
                        o.r   = int'($signed(bus.res_remainder));
                        o.dbz = int'(bus.res_dbz);
                        o.ovf = int'(bus.res_ovf);
                        o.lat = obs_lat;
                        lg.push_back(o);
                        void'(eq.pop_front());
                        busy = 0; seen = 0;
                        n_res++;
                    end
                end
            end else if (busy && cyc - acc_cyc + 1 > W + 1) begin
                fail("result_timeout");
                eq.delete();
                busy = 0;
            end
            prev_hold = bus.res_valid && !bus.res_ready;
            prev_out  = cur;
            if (|(bus.req_valid & bus.req_ready)) begin
                int g;
                g = bus.req_ready[1] ? 1 : 0;
                eq.push_back(model(g, int'($signed(bus.req_dividend[g*W +: W])), int'($signed(bus.req_divisor[g*W +: W]))));
                busy = 1;
                rr = (g == 0);
                acc_cyc = cyc + 1;
            end
        end
    end
    task automatic send(input int i, input int a, input int b);
        bit ok;
        ok = 0;
        bus.req_valid[i] = 1'b1;
        bus.req_dividend[i*W +: W] = W'(a);
        bus.req_divisor[i*W +: W]  = W'(b);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready[i]) ok = 1;
        end
        if (!ok) fail("accept_timeout");
        @(posedge clk);
        #1;
        bus.req_valid[i] = 1'b0;
        bus.req_dividend = 16'($urandom);
        bus.req_divisor  = 16'($urandom);
    endtask
    task automatic wait_res(input int target);
        for (int k = 0; k < 60 && n_res < target; k++) begin
            @(posedge clk);
            #1;
        end
        if (n_res < target) fail("wait_result");
    endtask
    task automatic chk_log(input int idx, input int id, input int q, input int r, input int dbz, input int ovf, input int lat);
        if (idx >= lg.size()) begin
            fail("log_missing");
        end else begin
            chk("lit_id", lg[idx].id, id);
            chk("lit_q", lg[idx].q, q);
            chk("lit_r", lg[idx].r, r);
            chk("lit_dbz", lg[idx].dbz, dbz);
            chk("lit_ovf", lg[idx].ovf, ovf);
            chk("lit_lat", lg[idx].lat, lat);
        end
    endtask
    initial begin
        int base;
        bus.req_valid = 2'b00;
        bus.req_dividend = '0;
        bus.req_divisor = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        base = n_res;
        send(0, 100, 5);
        wait_res(base + 1);
        chk_log(base, 0, 20, 0, 0, 0, 9);
        base = n_res;
        send(1, -50, 3);
        wait_res(base + 1);
        send(1, 75, -8);
        wait_res(base + 2);
        chk_log(base, 1, -16, -2, 0, 0, 9);
        chk_log(base + 1, 1, -9, 3, 0, 0, 9);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = n_res;
        bus.req_dividend = {8'sd9, 8'sd10};
        bus.req_divisor  = {8'sd2, 8'sd3};
        bus.req_valid    = 2'b11;
        for (int k = 0; k < 100 && n_res < base + 3; k++) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid = 2'b00;
        if (n_res < base + 3) fail("arbitration_results");
        chk_log(base, 0, 3, 1, 0, 0, 9);
        chk_log(base + 1, 1, 4, 1, 0, 0, 9);
        chk_log(base + 2, 0, 3, 1, 0, 0, 9);
        wait_res(base + 3);
        repeat (2) @(posedge clk);
        #1;
        base = n_res;
        send(0, 75, 0);
        wait_res(base + 1);
        send(0, -128, -1);
        wait_res(base + 2);
        chk_log(base, 0, -1, 75, 1, 0, 1);
        chk_log(base + 1, 0, -128, 0, 0, 1, 9);
        base = n_res;
        bus.res_ready = 1'b0;
        send(0, 20, 6);
        for (int k = 0; k < 30 && !bus.res_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_valid_seen", int'(bus.res_valid), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_ready_zero", int'(bus.req_ready), 0);
        end
        chk("bp_still_valid", int'(bus.res_valid), 1);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", int'(bus.res_valid), 0);
        chk("bp_count", n_res, base + 1);
        chk_log(base, 0, 3, 2, 0, 0, 9);
        base = n_res;
        send(0, 50, 7);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_outputs", int'({bus.res_valid, bus.res_id, bus.res_quotient, bus.res_remainder, bus.res_dbz, bus.res_ovf, bus.req_ready}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", n_res, base);
        send(0, 7, 2);
        wait_res(base + 1);
        chk_log(base, 0, 3, 1, 0, 0, 9);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sa_div_scheduler.md
SA_DIV_SCHEDULER -- requirements
Module: sa_div_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits, two's complement, minimum 4.
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH+1): width of the iteration counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-007 req_dividend  input  2*WIDTH  signed dividend; requester i in slice [i*WIDTH +: WIDTH].
REQ-008 req_divisor  input  2*WIDTH  signed divisor, sliced the same way as req_dividend.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_id  output  1  index of the requester that owns the result.
REQ-012 res_quotient  output  WIDTH  signed quotient.
REQ-013 res_remainder  output  WIDTH  signed remainder.
REQ-014 res_dbz  output  1  divide-by-zero flag.
REQ-015 res_ovf  output  1  overflow flag, set only for most-negative / -1.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE the grant SHALL be combinational: the single valid requester, or, when both are valid, the requester selected by the round-robin pointer rr.
REQ-018 req_ready SHALL be one-hot to the granted requester in IDLE, and zero in RUN, DONE and reset.
REQ-019 On a transfer, the block SHALL latch the operands and the id, and flip rr to the other requester.
REQ-020 On a transfer with divisor zero, the FSM SHALL go IDLE->DONE, so res_valid rises 1 cycle after the accept edge.
REQ-021 On a transfer with divisor non-zero, the FSM SHALL go IDLE->RUN.
REQ-022 RUN SHALL last exactly WIDTH cycles, with one restoring-division step per cycle on magnitudes; the FSM then goes to DONE.
REQ-023 res_valid SHALL rise WIDTH+1 cycles after the accept edge for a non-zero divisor.
REQ-024 In DONE, res_valid=1 and all res_* outputs SHALL hold stable until res_valid and res_ready are both high at a rising edge; the FSM then goes to IDLE.
REQ-025 No new request SHALL be accepted in the same cycle as the result handshake.
REQ-026 Arithmetic SHALL truncate toward zero: the quotient is negative iff the operand signs differ, and the remainder takes the sign of the dividend.
REQ-027 Every result SHALL satisfy |remainder| < |divisor| and dividend = quotient*divisor + remainder.
REQ-028 Divisor 0 SHALL give quotient = all ones (-1), remainder = dividend, res_dbz=1 and res_ovf=0.
REQ-029 Most-negative / -1 SHALL give quotient = most-negative (wrap), remainder 0, res_ovf=1 and res_dbz=0.
REQ-030 Operand changes while the block is not in IDLE SHALL have no effect; only latched values are used.
REQ-031 A requester that drops req_valid before being granted SHALL lose its place; there is no queuing.

Reset
REQ-032 On reset assertion, the state SHALL go to IDLE and rr SHALL be 0 (requester 0 wins the first conflict).
REQ-033 On reset assertion, the iteration counter SHALL be 0.
REQ-034 On reset assertion, res_valid, res_id, res_quotient, res_remainder, res_dbz and res_ovf SHALL all be 0.
REQ-035 Reset asserted in RUN or DONE SHALL abort the operation immediately and discard the result; no res_valid pulse follows.
REQ-036 req_ready SHALL be 0 throughout reset.

Structure
REQ-037 A shared package sa_div_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-038 The iterative magnitude datapath SHALL be a sub-module sa_div_core.
REQ-039 sa_div_core SHALL have load/start and done ports, unsigned WIDTH-bit operands, and unsigned quotient and remainder outputs.
REQ-040 Sign fix-up, dbz/ovf detection, arbitration and the handshake logic SHALL stay in sa_div_scheduler.

Verification
REQ-041 Requester 0 sends 100/5 with res_ready=1 -> res_valid 9 cycles after accept, q=20, r=0, id=0, dbz=0, ovf=0.
REQ-042 Requester 1 sends -50/3 -> q=-16, r=-2, id=1; requester 1 sends 75/-8 -> q=-9, r=3.
REQ-043 Both requesters valid every cycle from reset (0 sends 10/3, 1 sends 9/2) -> results in order id 0 (q=3, r=1), id 1 (q=4, r=1), id 0; req_ready is never high for both at once.
REQ-044 Requester 0 sends 75/0 -> res_valid 1 cycle after accept, q=-1, r=75, dbz=1; then -128/-1 -> q=-128, r=0, ovf=1.
REQ-045 Hold res_ready=0 for 5 cycles in DONE -> outputs stable, req_ready=0 throughout; the result is released on the first res_ready=1 edge.
REQ-046 Assert rst in the 4th RUN cycle -> all outputs zero at once, no res_valid afterwards; the next request 7/2 gives q=3, r=1.
